// File: rtl/hog_pio_pkg.sv
// hog_pio_pkg: shared PIO field positions, frame size and status packing for the HOG test-image path
package hog_pio_pkg;
  localparam int CMD_PIX_LSB = 0;
  localparam int CMD_PIX_W = 8;
  localparam int CMD_TOGGLE = 8;
  localparam int CMD_CLEAR = 9;
  localparam int ST_LEVEL_LSB = 0;
  localparam int ST_LEVEL_W = 5;
  localparam int ST_ACK = 8;
  localparam int ST_OVF = 9;
  localparam int ST_FULL = 10;
  localparam int ST_EMPTY = 11;
  localparam int ST_FRAME_LSB = 16;
  localparam int ST_FRAME_W = 8;
  localparam int FRAME_PIXELS_VGA = 640 * 480;

  function automatic logic [31:0] pack_status(input logic [ST_LEVEL_W-1:0] level, input logic ack,
                                              input logic ovf, input logic full, input logic empty,
                                              input logic [ST_FRAME_W-1:0] frames);
    logic [31:0] s;
    s = '0;
    s[ST_LEVEL_LSB +: ST_LEVEL_W] = level;
    s[ST_ACK] = ack;
    s[ST_OVF] = ovf;
    s[ST_FULL] = full;
    s[ST_EMPTY] = empty;
    s[ST_FRAME_LSB +: ST_FRAME_W] = frames;
    return s;
  endfunction
endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word fall-through FIFO; push is refused when full, flush overrides push and pop
module sync_fifo_fwft #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW = $clog2(DEPTH),
  parameter int LW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_level;
  logic w_push, w_pop;

  assign full = r_level == LW'(DEPTH);
  assign empty = r_level == '0;
  assign level = r_level;
  assign w_push = push && !full && !flush;
  assign w_pop = pop && !empty && !flush;
  // Head entry is masked to zero while empty so the stream data rests at 0
  assign dout = empty ? '0 : r_mem[r_rd];

  // Storage: written only on an accepted push
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  // Pointers and level; pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
    end else if (flush) begin
      r_wr <= '0;
      r_rd <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
    end
  end
endmodule

// File: rtl/pio_pixel_injector.sv
// pio_pixel_injector: turns toggle-paced host PIO writes into a valid/ready pixel stream with frame status
module pio_pixel_injector
  import hog_pio_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_PIXELS = FRAME_PIXELS_VGA
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cmd_pio,
  output logic [7:0]  pix_out_data,
  output logic        pix_out_valid,
  input  logic        pix_out_ready,
  output logic        frame_done,
  output logic [31:0] status_pio,
  output logic [31:0] pixel_count_pio
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  logic [9:0] r_cmd_q;
  logic r_last_toggle, r_overflow, r_frame_done;
  logic [31:0] r_pix_cnt;
  logic [7:0] r_frame_cnt;
  logic w_new, w_clear, w_push, w_pop, w_xfer, w_wrap, w_full, w_empty, w_unused;
  logic [LW-1:0] w_level;

  assign w_unused = ^cmd_pio[31:10];
  assign w_new = r_cmd_q[CMD_TOGGLE] != r_last_toggle;
  assign w_clear = w_new && r_cmd_q[CMD_CLEAR];
  assign w_push = w_new && !r_cmd_q[CMD_CLEAR];
  assign w_pop = !w_empty && pix_out_ready;
  assign w_xfer = w_pop && !w_clear;
  assign w_wrap = w_xfer && r_pix_cnt == 32'(FRAME_PIXELS - 1);

  sync_fifo_fwft #(.WIDTH(CMD_PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(w_push),
    .pop(w_pop),
    .flush(w_clear),
    .din(r_cmd_q[CMD_PIX_LSB +: CMD_PIX_W]),
    .dout(pix_out_data),
    .full(w_full),
    .empty(w_empty),
    .level(w_level)
  );

  assign pix_out_valid = !w_empty;
  assign frame_done = r_frame_done;
  assign pixel_count_pio = r_pix_cnt;
  assign status_pio = pack_status(ST_LEVEL_W'(w_level), r_last_toggle, r_overflow, w_full, w_empty, r_frame_cnt);

  // Command capture, ack toggle, sticky overflow and frame progress; a clear beats a same-cycle transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd_q <= '0;
      r_last_toggle <= 1'b0;
      r_overflow <= 1'b0;
      r_pix_cnt <= '0;
      r_frame_cnt <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_cmd_q <= cmd_pio[9:0];
      if (w_new) r_last_toggle <= r_cmd_q[CMD_TOGGLE];
      r_overflow <= w_clear ? 1'b0 : r_overflow | (w_push && w_full);
      r_pix_cnt <= (w_clear || w_wrap) ? '0 : r_pix_cnt + 32'(w_xfer);
      r_frame_cnt <= w_clear ? '0 : r_frame_cnt + 8'(w_wrap);
      r_frame_done <= w_wrap;
    end
  end
endmodule

// File: tb/tb_pio_pixel_injector.sv
// tb_pio_pixel_injector: directed and random checks against a queue-based model of the injector
module tb_pio_pixel_injector;
  localparam int DEPTH = 16;
  localparam int FP = 4;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] cmd_pio;
  logic pix_out_ready;
  logic [7:0] pix_out_data;
  logic pix_out_valid, frame_done;
  logic [31:0] status_pio, pixel_count_pio;
  int tests = 0;
  int fails = 0;
  int fd_seen = 0;
  logic [7:0] q[$];
  logic m_ack, m_ovf, m_fd, tog;
  logic [9:0] m_cmdq;
  int m_cnt, m_frames;

  pio_pixel_injector #(.FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FP)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_pio(cmd_pio),
    .pix_out_data(pix_out_data),
    .pix_out_valid(pix_out_valid),
    .pix_out_ready(pix_out_ready),
    .frame_done(frame_done),
    .status_pio(status_pio),
    .pixel_count_pio(pixel_count_pio)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'h0;
    s[4:0] = 5'(q.size());
    s[8] = m_ack;
    s[9] = m_ovf;
    s[10] = q.size() == DEPTH;
    s[11] = q.size() == 0;
    s[23:16] = 8'(m_frames);
    return s;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ack = 0; m_ovf = 0; m_fd = 0; m_cmdq = '0; m_cnt = 0; m_frames = 0; tog = 0;
  endtask

  task automatic check_all();
    chk("valid", 32'(pix_out_valid), 32'(q.size() != 0));
    chk("data", 32'(pix_out_data), q.size() != 0 ? 32'(q[0]) : 32'h0);
    chk("status", status_pio, exp_status());
    chk("pixcnt", pixel_count_pio, 32'(m_cnt));
    chk("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  task automatic tick();
    bit nw, full, xfer;
    @(posedge clk);
    nw = m_cmdq[8] != m_ack;
    full = q.size() == DEPTH;
    xfer = q.size() != 0 && pix_out_ready;
    m_fd = 0;
    if (nw && m_cmdq[9]) begin
      q.delete(); m_cnt = 0; m_frames = 0; m_ovf = 0;
    end else begin
      if (xfer) begin
        void'(q.pop_front());
        m_cnt++;
        if (m_cnt == FP) begin
          m_cnt = 0; m_frames = (m_frames + 1) % 256; m_fd = 1;
        end
      end
      if (nw) begin
        if (full) m_ovf = 1;
        else q.push_back(m_cmdq[7:0]);
      end
    end
    if (nw) m_ack = m_cmdq[8];
    m_cmdq = cmd_pio[9:0];
    #1;
    if (frame_done === 1'b1) fd_seen++;
    check_all();
  endtask

  task automatic host_write(input logic [7:0] pix, input logic clr);
    tog = ~tog;
    cmd_pio = {22'h0, clr, tog, pix};
    tick();
    tick();
  endtask

  task automatic reset_checks();
    chk("rst_valid", 32'(pix_out_valid), 32'h0);
    chk("rst_data", 32'(pix_out_data), 32'h0);
    chk("rst_status", status_pio, 32'h0000_0800);
    chk("rst_pixcnt", pixel_count_pio, 32'h0);
    chk("rst_fd", 32'(frame_done), 32'h0);
  endtask

  initial begin
    rst = 1; cmd_pio = '0; pix_out_ready = 0;
    model_reset();
    #1;
    reset_checks();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick();
    // first pixel and a single transfer
    host_write(8'h5A, 0);
    chk("t1_ack", 32'(status_pio[8]), 32'h1);
    chk("t1_valid", 32'(pix_out_valid), 32'h1);
    chk("t1_data", 32'(pix_out_data), 32'h5A);
    pix_out_ready = 1;
    tick();
    pix_out_ready = 0;
    chk("t1_empty", 32'(status_pio[11]), 32'h1);
    chk("t1_pixcnt", pixel_count_pio, 32'h1);
    // overflow on the 17th pixel and in-order drain
    for (int i = 0; i < 17; i++) host_write(8'(i), 0);
    chk("t2_level", 32'(status_pio[4:0]), 32'd16);
    chk("t2_full", 32'(status_pio[10]), 32'h1);
    chk("t2_ovf", 32'(status_pio[9]), 32'h1);
    pix_out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain", 32'(pix_out_data), 32'(i));
      tick();
    end
    pix_out_ready = 0;
    chk("t2_empty", 32'(status_pio[11]), 32'h1);
    // unchanged toggle is ignored
    host_write(8'h33, 0);
    for (int i = 0; i < 3; i++) begin
      cmd_pio = {22'h0, 1'b0, tog, 8'hAB};
      tick(); tick();
    end
    chk("t3_level", 32'(status_pio[4:0]), 32'd1);
    chk("t3_ack", 32'(status_pio[8]), 32'(tog));
    chk("t3_data", 32'(pix_out_data), 32'h33);
    // frame wrap with FRAME_PIXELS=4
    host_write(8'h00, 1);
    pix_out_ready = 1;
    fd_seen = 0;
    for (int i = 0; i < 9; i++) host_write(8'($urandom), 0);
    tick();
    chk("t4_fd_pulses", 32'(fd_seen), 32'd2);
    chk("t4_frames", 32'(status_pio[23:16]), 32'd2);
    chk("t4_pixcnt", pixel_count_pio, 32'd1);
    // clear coinciding with a transfer at the frame's last pixel
    pix_out_ready = 0;
    host_write(8'h00, 1);
    for (int i = 0; i < 17; i++) host_write(8'(i + 64), 0);
    pix_out_ready = 1;
    repeat (11) tick();
    pix_out_ready = 0;
    chk("t5_pre_level", 32'(status_pio[4:0]), 32'd5);
    chk("t5_pre_ovf", 32'(status_pio[9]), 32'h1);
    tog = ~tog;
    cmd_pio = {22'h0, 1'b1, tog, 8'h00};
    tick();
    pix_out_ready = 1;
    tick();
    pix_out_ready = 0;
    chk("t5_level", 32'(status_pio[4:0]), 32'd0);
    chk("t5_empty", 32'(status_pio[11]), 32'h1);
    chk("t5_ovf", 32'(status_pio[9]), 32'h0);
    chk("t5_frames", 32'(status_pio[23:16]), 32'h0);
    chk("t5_pixcnt", pixel_count_pio, 32'h0);
    chk("t5_fd", 32'(frame_done), 32'h0);
    // random traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      pix_out_ready = 1'($urandom_range(0, 1));
      if (r < 6) begin
        tog = ~tog;
        cmd_pio = {22'($urandom), 1'b0, tog, 8'($urandom)};
      end else if (r == 6) begin
        tog = ~tog;
        cmd_pio = {22'h0, 1'b1, tog, 8'($urandom)};
      end
      tick();
    end
    // asynchronous reset with pixels queued
    pix_out_ready = 0;
    host_write(8'h11, 0);
    host_write(8'h22, 0);
    host_write(8'h33, 0);
    #2;
    rst = 1;
    cmd_pio = '0;
    #1;
    model_reset();
    reset_checks();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    tick();
    host_write(8'h77, 0);
    chk("t6_restart", 32'(pix_out_data), 32'h77);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
